// File: rtl/vmu_stride_agen.sv
// Vector memory unit address generator for unit-stride and strided commands.
// Latency: first beat is valid AGEN_DELAY cycles after the command is accepted, then one beat per cycle.
// Backpressure: while o_addr_valid is high and i_addr_ready is low, every stage and beat issue are frozen.
//
// Ports:
//   clk, rst_n                  single clock; synchronous active-low reset
//   i_cmd_valid / o_cmd_ready   command handshake (ready only while the FSM is idle)
//   i_cmd_mode                  0 unit-stride (stride = element size), 1 strided
//   i_cmd_eew                   element size is 2^eew bytes
//   i_cmd_base, i_cmd_stride    base address and signed byte stride
//   i_cmd_vl                    element count, clamped to VLMAX
//   o_addr_valid / i_addr_ready beat handshake
//   o_addr                      NUM_LANE lane addresses, lane 0 in the LSBs
//   o_lane_mask                 active lanes of the beat
//   o_beat_idx, o_last          beat number within the command, final-beat flag
//   o_busy                      FSM generating or a beat still in the pipeline
module vmu_stride_agen #(
  parameter int SCALAR_WIDTH = 32,
  parameter int NUM_LANE     = 4,
  parameter int VLMAX        = 64,
  parameter int AGEN_DELAY   = 2
) (
  input  logic                                  clk,
  input  logic                                  rst_n,
  input  logic                                  i_cmd_valid,
  output logic                                  o_cmd_ready,
  input  logic                                  i_cmd_mode,
  input  logic [1:0]                            i_cmd_eew,
  input  logic [SCALAR_WIDTH-1:0]               i_cmd_base,
  input  logic [SCALAR_WIDTH-1:0]               i_cmd_stride,
  input  logic [$clog2(VLMAX):0]                i_cmd_vl,
  output logic                                  o_addr_valid,
  input  logic                                  i_addr_ready,
  output logic [NUM_LANE*SCALAR_WIDTH-1:0]      o_addr,
  output logic [NUM_LANE-1:0]                   o_lane_mask,
  output logic [$clog2(VLMAX/NUM_LANE)-1:0]     o_beat_idx,
  output logic                                  o_last,
  output logic                                  o_busy
);

  localparam int VLW = $clog2(VLMAX) + 1;
  localparam int BIW = $clog2(VLMAX / NUM_LANE);
  localparam int LSH = $clog2(NUM_LANE);
  localparam int AW  = NUM_LANE * SCALAR_WIDTH;

  typedef struct packed {
    logic [AW-1:0]       addr;
    logic [NUM_LANE-1:0] mask;
    logic [BIW-1:0]      idx;
    logic                last;
  } beat_t;

  typedef enum logic [0:0] {S_IDLE, S_GEN} state_t;

  state_t                  r_state;
  state_t                  w_state_nxt;

  logic [SCALAR_WIDTH-1:0] r_l0;       // lane-0 address of the next beat to issue
  logic [SCALAR_WIDTH-1:0] r_stride;
  logic [VLW-1:0]          r_remain;   // elements not yet issued
  logic [BIW-1:0]          r_beat;

  logic                    r_pv [AGEN_DELAY];
  beat_t                   r_pd [AGEN_DELAY];

  logic                    w_stall;
  logic                    w_accept;
  logic                    w_issue;
  logic                    w_last_beat;
  logic                    w_any_vld;
  logic [VLW-1:0]          w_vl_eff;
  logic [SCALAR_WIDTH-1:0] w_stride_eff;
  beat_t                   w_beat;

  assign w_stall      = r_pv[AGEN_DELAY-1] & ~i_addr_ready;
  assign w_accept     = i_cmd_valid & o_cmd_ready;
  assign w_vl_eff     = (i_cmd_vl > VLW'(VLMAX)) ? VLW'(VLMAX) : i_cmd_vl;
  assign w_stride_eff = i_cmd_mode ? i_cmd_stride : (SCALAR_WIDTH'(1) << i_cmd_eew);
  assign w_last_beat  = (r_remain <= VLW'(NUM_LANE));

  // FSM: state register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // FSM: next state. A zero-length command is consumed without leaving IDLE.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: if (w_accept && (w_vl_eff != '0)) w_state_nxt = S_GEN;
      S_GEN:  if (w_issue && w_last_beat)       w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // FSM: outputs
  always_comb begin
    o_cmd_ready = 1'b0;
    w_issue     = 1'b0;
    case (r_state)
      S_IDLE:  o_cmd_ready = 1'b1;
      S_GEN:   w_issue     = ~w_stall;
      default: o_cmd_ready = 1'b0;
    endcase
  end

  // Command registers. Accept and issue are exclusive because ready is only high in IDLE.
  // The lane-0 address advances by NUM_LANE*stride per beat, so no multiply by beat index.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_l0     <= '0;
      r_stride <= '0;
      r_remain <= '0;
      r_beat   <= '0;
    end else if (w_accept) begin
      r_l0     <= i_cmd_base;
      r_stride <= w_stride_eff;
      r_remain <= w_vl_eff;
      r_beat   <= '0;
    end else if (w_issue) begin
      r_l0     <= r_l0 + (r_stride << LSH);
      r_remain <= w_last_beat ? '0 : (r_remain - VLW'(NUM_LANE));
      r_beat   <= r_beat + BIW'(1);
    end
  end

  // Lane addresses of the beat about to issue; the per-lane factor is a constant.
  always_comb begin
    w_beat      = '0;
    w_beat.idx  = r_beat;
    w_beat.last = w_last_beat;
    for (int l = 0; l < NUM_LANE; l++) begin
      if (VLW'(l) < r_remain) begin
        w_beat.mask[l]                            = 1'b1;
        w_beat.addr[l*SCALAR_WIDTH +: SCALAR_WIDTH] = r_l0 + SCALAR_WIDTH'(l) * r_stride;
      end
    end
  end

  // Delay pipeline; a stall freezes every stage, bubbles included.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int k = 0; k < AGEN_DELAY; k++) begin
        r_pv[k] <= 1'b0;
        r_pd[k] <= '0;
      end
    end else if (!w_stall) begin
      r_pv[0] <= w_issue;
      r_pd[0] <= w_beat;
      for (int k = 1; k < AGEN_DELAY; k++) begin
        r_pv[k] <= r_pv[k-1];
        r_pd[k] <= r_pd[k-1];
      end
    end
  end

  always_comb begin
    w_any_vld = 1'b0;
    for (int k = 0; k < AGEN_DELAY; k++) begin
      w_any_vld = w_any_vld | r_pv[k];
    end
  end

  assign o_busy       = (r_state == S_GEN) | w_any_vld;
  assign o_addr_valid = r_pv[AGEN_DELAY-1];
  assign o_addr       = o_addr_valid ? r_pd[AGEN_DELAY-1].addr : '0;
  assign o_lane_mask  = o_addr_valid ? r_pd[AGEN_DELAY-1].mask : '0;
  assign o_beat_idx   = o_addr_valid ? r_pd[AGEN_DELAY-1].idx  : '0;
  assign o_last       = o_addr_valid & r_pd[AGEN_DELAY-1].last;

endmodule

// File: tb/tb_vmu_stride_agen.sv
// Directed testbench for vmu_stride_agen with NUM_LANE=4, SCALAR_WIDTH=32, AGEN_DELAY=2.
// Latency: inputs driven and outputs sampled on the falling edge.
// Backpressure: i_addr_ready held high except for an explicit three-cycle stall.
module tb_vmu_stride_agen;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         i_cmd_valid = 1'b0;
  logic         o_cmd_ready;
  logic         i_cmd_mode = 1'b0;
  logic [1:0]   i_cmd_eew = '0;
  logic [31:0]  i_cmd_base = '0;
  logic [31:0]  i_cmd_stride = '0;
  logic [6:0]   i_cmd_vl = '0;
  logic         o_addr_valid;
  logic         i_addr_ready = 1'b1;
  logic [127:0] o_addr;
  logic [3:0]   o_lane_mask;
  logic [3:0]   o_beat_idx;
  logic         o_last;
  logic         o_busy;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  vmu_stride_agen #(
    .SCALAR_WIDTH(32), .NUM_LANE(4), .VLMAX(64), .AGEN_DELAY(2)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .i_cmd_valid(i_cmd_valid), .o_cmd_ready(o_cmd_ready),
    .i_cmd_mode(i_cmd_mode), .i_cmd_eew(i_cmd_eew),
    .i_cmd_base(i_cmd_base), .i_cmd_stride(i_cmd_stride), .i_cmd_vl(i_cmd_vl),
    .o_addr_valid(o_addr_valid), .i_addr_ready(i_addr_ready),
    .o_addr(o_addr), .o_lane_mask(o_lane_mask), .o_beat_idx(o_beat_idx),
    .o_last(o_last), .o_busy(o_busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Present a command, wait for ready, return the edge count of the accept edge.
  task automatic send_cmd(input logic m, input logic [1:0] e, input logic [31:0] b,
                          input logic [31:0] s, input logic [6:0] v, output int acc);
    int n = 0;
    i_cmd_mode   = m;
    i_cmd_eew    = e;
    i_cmd_base   = b;
    i_cmd_stride = s;
    i_cmd_vl     = v;
    i_cmd_valid  = 1'b1;
    while (!o_cmd_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("cmd_ready", o_cmd_ready, 1);
    @(negedge clk);
    i_cmd_valid = 1'b0;
    acc = cyc;
  endtask

  // Wait for a valid beat, compare it, and step past it (ready assumed high).
  task automatic expect_beat(input string tag, input logic [127:0] ea, input logic [3:0] em,
                             input logic [3:0] ei, input logic el, output int fc);
    int n = 0;
    while (!o_addr_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk({tag, ".vld"}, o_addr_valid, 1);
    fc = cyc;
    chk({tag, ".addr"}, o_addr, ea);
    chk({tag, ".mask"}, o_lane_mask, em);
    chk({tag, ".idx"}, o_beat_idx, ei);
    chk({tag, ".last"}, o_last, el);
    if (o_addr_valid) @(negedge clk);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int acc, f0, f1, errs;
    logic [127:0] ea;

    repeat (3) @(negedge clk);
    chk("rst.ready", o_cmd_ready, 1);
    chk("rst.vld", o_addr_valid, 0);
    chk("rst.busy", o_busy, 0);
    chk("rst.addr", o_addr, 0);
    chk("rst.last", o_last, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Unit stride, 4-byte elements, two full beats.
    send_cmd(1'b0, 2'd2, 32'h100, 32'hDEAD_BEEF, 7'd8, acc);
    expect_beat("t1.b0", {32'h10C, 32'h108, 32'h104, 32'h100}, 4'hF, 4'd0, 1'b0, f0);
    chk("t1.latency", f0 - acc, 2);
    expect_beat("t1.b1", {32'h11C, 32'h118, 32'h114, 32'h110}, 4'hF, 4'd1, 1'b1, f1);
    chk("t1.thru", f1 - f0, 1);
    chk("t1.end_vld", o_addr_valid, 0);
    chk("t1.end_addr", o_addr, 0);
    chk("t1.end_busy", o_busy, 0);

    // Negative stride, partial second beat.
    send_cmd(1'b1, 2'd2, 32'h40, 32'hFFFF_FFF8, 7'd6, acc);
    expect_beat("t2.b0", {32'h28, 32'h30, 32'h38, 32'h40}, 4'hF, 4'd0, 1'b0, f0);
    expect_beat("t2.b1", {32'h0, 32'h0, 32'h18, 32'h20}, 4'h3, 4'd1, 1'b1, f1);

    // Address wrap past 2^32.
    send_cmd(1'b0, 2'd2, 32'hFFFF_FFFC, 32'h0, 7'd4, acc);
    expect_beat("t3.b0", {32'h8, 32'h4, 32'h0, 32'hFFFF_FFFC}, 4'hF, 4'd0, 1'b1, f0);

    // Three-cycle stall on beat 1 of a four-beat command.
    send_cmd(1'b0, 2'd0, 32'h1000, 32'h0, 7'd16, acc);
    expect_beat("t4.b0", {32'h1003, 32'h1002, 32'h1001, 32'h1000}, 4'hF, 4'd0, 1'b0, f0);
    ea = {32'h1007, 32'h1006, 32'h1005, 32'h1004};
    i_addr_ready = 1'b0;
    chk("t4.stall_vld0", o_addr_valid, 1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("t4.stall_vld", o_addr_valid, 1);
      chk("t4.stall_addr", o_addr, ea);
      chk("t4.stall_idx", o_beat_idx, 1);
    end
    i_addr_ready = 1'b1;
    expect_beat("t4.b1", ea, 4'hF, 4'd1, 1'b0, f0);
    expect_beat("t4.b2", {32'h100B, 32'h100A, 32'h1009, 32'h1008}, 4'hF, 4'd2, 1'b0, f0);
    expect_beat("t4.b3", {32'h100F, 32'h100E, 32'h100D, 32'h100C}, 4'hF, 4'd3, 1'b1, f0);
    chk("t4.end_vld", o_addr_valid, 0);

    // Zero-length command produces nothing.
    send_cmd(1'b0, 2'd2, 32'h500, 32'h0, 7'd0, acc);
    errs = 0;
    for (int i = 0; i < 6; i++) begin
      if (o_addr_valid !== 1'b0 || o_cmd_ready !== 1'b1 || o_busy !== 1'b0) errs++;
      @(negedge clk);
    end
    chk("t5.vl0_quiet", errs, 0);

    // vl=100 clamps to 64 elements: 16 beats of 8-byte elements.
    send_cmd(1'b0, 2'd3, 32'h0, 32'h0, 7'd100, acc);
    for (int b = 0; b < 16; b++) begin
      ea = {32'(b*32 + 24), 32'(b*32 + 16), 32'(b*32 + 8), 32'(b*32)};
      expect_beat($sformatf("t6.b%0d", b), ea, 4'hF, 4'(b), (b == 15), f0);
    end
    errs = 0;
    for (int i = 0; i < 4; i++) begin
      if (o_addr_valid !== 1'b0) errs++;
      @(negedge clk);
    end
    chk("t6.no_extra", errs, 0);

    // Second command accepted while the first is still in the pipeline.
    send_cmd(1'b0, 2'd2, 32'h200, 32'h0, 7'd4, acc);
    send_cmd(1'b1, 2'd0, 32'h300, 32'h10, 7'd2, acc);
    expect_beat("t7.a", {32'h20C, 32'h208, 32'h204, 32'h200}, 4'hF, 4'd0, 1'b1, f0);
    expect_beat("t7.b", {32'h0, 32'h0, 32'h310, 32'h300}, 4'h3, 4'd0, 1'b1, f1);

    // Reset in the middle of a command.
    send_cmd(1'b0, 2'd2, 32'h5000, 32'h0, 7'd16, acc);
    expect_beat("t8.b0", {32'h500C, 32'h5008, 32'h5004, 32'h5000}, 4'hF, 4'd0, 1'b0, f0);
    rst_n = 1'b0;
    @(negedge clk);
    chk("t8.rst_vld", o_addr_valid, 0);
    chk("t8.rst_busy", o_busy, 0);
    chk("t8.rst_ready", o_cmd_ready, 1);
    rst_n = 1'b1;
    errs = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (o_addr_valid !== 1'b0) errs++;
    end
    chk("t8.no_stale", errs, 0);
    send_cmd(1'b0, 2'd2, 32'h7000, 32'h0, 7'd4, acc);
    expect_beat("t8.new", {32'h700C, 32'h7008, 32'h7004, 32'h7000}, 4'hF, 4'd0, 1'b1, f0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/vmu_stride_agen.md
VMU_STRIDE_AGEN -- requirements
Module: vmu_stride_agen

Interface
REQ-001 Parameter SCALAR_WIDTH, default 32, address/scalar width.
REQ-002 Parameter NUM_LANE, default 4, addresses per beat (power of 2).
REQ-003 Parameter VLMAX, default 64, max elements per command (power of 2, multiple of NUM_LANE).
REQ-004 Parameter AGEN_DELAY, default 2, pipeline stages accept-to-output (>=1).
REQ-005 clk  in  1  single clock, rising edge.
REQ-006 rst_n  in  1  reset, synchronous, active-low.
REQ-007 i_cmd_valid  in  1  command valid.
REQ-008 o_cmd_ready  out  1  command ready.
REQ-009 i_cmd_mode  in  1  0 unit-stride, 1 strided.
REQ-010 i_cmd_eew  in  2  element size 2^eew bytes.
REQ-011 i_cmd_base  in  SCALAR_WIDTH  base address.
REQ-012 i_cmd_stride  in  SCALAR_WIDTH  signed byte stride (strided mode only).
REQ-013 i_cmd_vl  in  $clog2(VLMAX)+1  element count.
REQ-014 o_addr_valid  out  1  beat valid.
REQ-015 i_addr_ready  in  1  downstream accepts beat.
REQ-016 o_addr  out  NUM_LANE*SCALAR_WIDTH  lane addresses, lane 0 in LSBs.
REQ-017 o_lane_mask  out  NUM_LANE  active lanes of beat.
REQ-018 o_beat_idx  out  $clog2(VLMAX/NUM_LANE)  beat number within command.
REQ-019 o_last  out  1  final beat of command.
REQ-020 o_busy  out  1  FSM in GEN or any pipeline stage holds a beat.

Function
REQ-021 FSM states IDLE, GEN; o_cmd_ready=1 only in IDLE; command accepted on edge with i_cmd_valid&o_cmd_ready.
REQ-022 Accept with effective vl>0: latch base, stride, vl; IDLE->GEN; beat counter=0.
REQ-023 Accept with vl=0: consumed, no beats, FSM stays IDLE.
REQ-024 Effective vl = min(i_cmd_vl, VLMAX).
REQ-025 Effective stride = (1<<eew) in unit mode (i_cmd_stride ignored), i_cmd_stride in strided mode.
REQ-026 Beat b lane l address = base + (b*NUM_LANE+l)*stride, modulo 2^SCALAR_WIDTH (wrap, no flag).
REQ-027 Implementation incremental: lane-0 register advances by NUM_LANE*stride per issued beat; no multiplier on b.
REQ-028 Beats per command = ceil(vl/NUM_LANE); lane l active iff b*NUM_LANE+l < vl; inactive lanes output address 0.
REQ-029 GEN issues one beat per cycle into pipeline when not stalled; after issuing last beat -> IDLE same edge.
REQ-030 New command may be accepted while earlier beats drain; in-order output, no bubble required.
REQ-031 Pipeline: AGEN_DELAY stages; beat issued at edge E visible at o_addr after edge E+AGEN_DELAY-1; first beat valid AGEN_DELAY cycles after accept edge absent stall.
REQ-032 Stall = o_addr_valid & ~i_addr_ready; stall freezes all stages and beat issue; outputs held stable.
REQ-033 Throughput one beat/cycle under continuous i_addr_ready.
REQ-034 o_last=1 exactly on final beat of each command, with o_addr_valid.
REQ-035 o_addr, o_lane_mask, o_beat_idx, o_last zero when o_addr_valid=0.

Reset
REQ-036 rst_n=0 at edge: FSM IDLE, pipeline emptied, counters 0; after that edge o_cmd_ready=1, all other outputs 0.
REQ-037 Reset mid-command discards in-flight beats; no beat of aborted command appears after reset.

Verification (NUM_LANE=4, SCALAR_WIDTH=32, AGEN_DELAY=2)
REQ-038 Unit, eew=2, base 0x100, vl=8 -> beat0 {0x100,0x104,0x108,0x10C} mask 1111; beat1 {0x110,0x114,0x118,0x11C} last=1; first valid 2 cycles after accept.
REQ-039 Strided, stride 0xFFFFFFF8, base 0x40, vl=6 -> beat0 {0x40,0x38,0x30,0x28}; beat1 {0x20,0x18,0,0} mask 0011 last=1.
REQ-040 Unit, eew=2, base 0xFFFFFFFC, vl=4 -> {0xFFFFFFFC,0x0,0x4,0x8}, last=1.
REQ-041 vl=16, i_addr_ready low 3 cycles at beat 1 -> beat 1 held stable, 4 beats total, idx 0..3, no loss/duplicate.
REQ-042 vl=0 -> no o_addr_valid, o_cmd_ready stays 1; vl=100 -> 16 beats (clamped).
REQ-043 rst_n low mid-command -> next cycle o_addr_valid=0, o_busy=0, o_cmd_ready=1; following command starts at beat_idx 0.
